// File: rtl/mp3_sdi_if.sv
// mp3_sdi_if: serial MP3 link lines plus the local byte-consumer side of the receiver.
interface mp3_sdi_if;
   logic       mp3_clk;
   logic       mp3_dat;
   logic       mp3_sync;
   logic       mp3_req;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_stb;
   logic       clr;
   logic       ovf;
   logic       frm_err;
   logic [15:0] byte_cnt;
   modport master (output mp3_clk, mp3_dat, mp3_sync, rd_stb, clr,
                   input  mp3_req, rd_data, rd_valid, ovf, frm_err, byte_cnt);
   modport slave  (input  mp3_clk, mp3_dat, mp3_sync, rd_stb, clr,
                   output mp3_req, rd_data, rd_valid, ovf, frm_err, byte_cnt);
endinterface

// File: rtl/mp3_sdi_rx.sv
// mp3_sdi_rx: decoder-side SDI receiver; syncs the serial link, assembles MSB-first bytes
// and buffers them in a show-ahead FIFO whose fill level drives mp3_req.
module mp3_sdi_rx #(
   parameter int DEPTH    = 16,
   parameter int REQ_FREE = 8
) (
   input  logic     clk,
   input  logic     rst,
   mp3_sdi_if.slave s
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE     = (AW+1)'(1);
   localparam logic [AW:0] FULL_N  = (AW+1)'(DEPTH);
   localparam logic [AW:0] REQ_MAX = (AW+1)'(DEPTH - REQ_FREE);

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t st, st_n;

   logic [2:0]  ck_q;
   logic [1:0]  dt_q, sy_q;
   logic [2:0]  bc, bc_n;
   logic [7:0]  sh, sh_n;
   logic        push, push_n, ferr_set;
   logic        bit_ev, dt, sy;
   logic [AW:0] wp, rp, cnt;
   logic [7:0]  mem [DEPTH];
   logic        full, pop, wr, rd_valid;
   logic        ovf_q, ferr_q, req_q;
   logic [15:0] bcnt_q;

   assign bit_ev = ck_q[1] & ~ck_q[2];
   assign dt = dt_q[1];
   assign sy = sy_q[1];
   assign cnt = wp - rp;
   assign full = cnt == FULL_N;
   assign rd_valid = cnt != '0;
   assign pop = s.rd_stb & rd_valid;
   // a pop in the same cycle frees the slot the push needs
   assign wr = push & (~full | pop);

   assign s.rd_valid = rd_valid;
   assign s.rd_data  = rd_valid ? mem[rp[AW-1:0]] : 8'h00;
   assign s.ovf      = ovf_q;
   assign s.frm_err  = ferr_q;
   assign s.byte_cnt = bcnt_q;
   assign s.mp3_req  = req_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ck_q <= '0;
         dt_q <= '0;
         sy_q <= '0;
         st   <= IDLE;
         bc   <= '0;
         sh   <= '0;
         push <= 1'b0;
      end else begin
         ck_q <= {ck_q[1:0], s.mp3_clk};
         dt_q <= {dt_q[0], s.mp3_dat};
         sy_q <= {sy_q[0], s.mp3_sync};
         st   <= st_n;
         bc   <= bc_n;
         sh   <= sh_n;
         push <= push_n;
      end
   end

   // sync always restarts a byte; mid-byte it also flags a framing error
   always_comb begin
      st_n     = st;
      bc_n     = bc;
      sh_n     = sh;
      push_n   = 1'b0;
      ferr_set = 1'b0;
      if (bit_ev) begin
         if (sy) begin
            st_n     = SHIFT;
            bc_n     = 3'd1;
            sh_n     = {7'd0, dt};
            ferr_set = st == SHIFT;
         end else if (st == SHIFT) begin
            sh_n   = {sh[6:0], dt};
            bc_n   = bc == 3'd7 ? 3'd0 : bc + 3'd1;
            st_n   = bc == 3'd7 ? IDLE : SHIFT;
            push_n = bc == 3'd7;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wp[AW-1:0]] <= sh;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp     <= '0;
         rp     <= '0;
         ovf_q  <= 1'b0;
         ferr_q <= 1'b0;
         bcnt_q <= '0;
         req_q  <= 1'b1;
      end else begin
         if (wr) wp <= wp + ONE;
         if (pop) rp <= rp + ONE;
         ovf_q  <= (push & ~wr) | (ovf_q & ~s.clr);
         ferr_q <= ferr_set | (ferr_q & ~s.clr);
         bcnt_q <= s.clr ? {15'd0, wr} : bcnt_q + {15'd0, wr};
         req_q  <= cnt <= REQ_MAX;
      end
   end
endmodule
